// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush controller for a 5-stage in-order core.
// It resolves load-use hazards, taken-branch flushes and data-memory wait states,
// and has a sticky timeout error that only reset clears. Control outputs are
// combinational from the registered state and the current inputs.
//
// Memory handshake: dmem_req marks an access issued by MEM this cycle, and
// dmem_ready marks its completion in the same cycle. A stall is dmem_req & !dmem_ready.
// dmem_ready without dmem_req carries no meaning and is ignored in every state.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_uses_rs2,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_writereg,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_hold,
  output logic        mem_timeout,
  output logic [1:0]  fsm_state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  // wait_cnt reaches this value on the last MEM_WAIT cycle before the error.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        branch_pending_q, branch_pending_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic load_use;
  logic mem_stall;
  logic mem_done;

  // Hazard detection. x0 is never a real destination, so it cannot cause a hazard.
  always_comb begin
    load_use  = id_ex_memread && (id_ex_writereg != 5'd0) &&
                ((id_ex_writereg == if_id_rs1) ||
                 (if_id_uses_rs2 && (id_ex_writereg == if_id_rs2)));
    mem_stall = dmem_req && !dmem_ready;
    mem_done  = dmem_req && dmem_ready;
  end

  // Next state and pipeline controls. In RUN the priority is memory stall, then branch, then load-use.
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    branch_pending_d = branch_pending_q;
    mem_timeout_d    = mem_timeout_q;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    ex_mem_hold      = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_write         = 1'b0;
          if_id_write      = 1'b0;
          ex_mem_hold      = 1'b1;
          state_d          = MEM_WAIT;
          wait_cnt_d       = 8'd0;
          branch_pending_d = ex_branch_taken;
        end else if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_done) begin
          pc_write         = 1'b0;
          if_id_write      = 1'b0;
          ex_mem_hold      = 1'b1;
          branch_pending_d = branch_pending_q || ex_branch_taken;
          if (wait_cnt_q == LAST_WAIT) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // A branch that resolved while memory was stalled is applied now.
          if (ex_branch_taken || branch_pending_q) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
          state_d          = RUN;
          branch_pending_d = 1'b0;
        end
      end
      ERROR: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_hold   = 1'b1;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // The pipeline is frozen without holding while reset is asserted.
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_hold  = 1'b0;
    end
  end

  // Saturating count of stalled cycles. ERROR cycles are not counted.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (state_q != ERROR) && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers. Reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      wait_cnt_q       <= 8'd0;
      branch_pending_q <= 1'b0;
      mem_timeout_q    <= 1'b0;
      stall_count_q    <= 16'd0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      branch_pending_q <= branch_pending_d;
      mem_timeout_q    <= mem_timeout_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign fsm_state   = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed test of hazard_stall_ctrl with TIMEOUT=4.
// Inputs change just after the falling edge. Each check happens 1ns later,
// so combinational controls and the registered outputs are stable when read.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        if_id_uses_rs2;
  logic        id_ex_memread;
  logic [4:0]  id_ex_writereg;
  logic        ex_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  wire         pc_write;
  wire         if_id_write;
  wire         if_id_flush;
  wire         id_ex_bubble;
  wire         ex_mem_hold;
  wire         mem_timeout;
  wire  [1:0]  fsm_state;
  wire  [15:0] stall_count;

  // Control bits in the order {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}.
  wire  [4:0]  ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};

  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_LU    = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_ZERO  = 5'b00000;

  int n_checks;
  int n_fail;
  int exp_stall;

  hazard_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .if_id_uses_rs2  (if_id_uses_rs2),
    .id_ex_memread   (id_ex_memread),
    .id_ex_writereg  (id_ex_writereg),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .mem_timeout     (mem_timeout),
    .fsm_state       (fsm_state),
    .stall_count     (stall_count)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic drive_idle();
    if_id_rs1       = 5'd0;
    if_id_rs2       = 5'd0;
    if_id_uses_rs2  = 1'b0;
    id_ex_memread   = 1'b0;
    id_ex_writereg  = 5'd0;
    ex_branch_taken = 1'b0;
    dmem_req        = 1'b0;
    dmem_ready      = 1'b0;
  endtask

  // Advance to the next falling edge. Inputs set after this apply to the next cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    id_ex_memread = 1'b1; id_ex_writereg = 5'd3; if_id_rs1 = 5'd3;
    next_cycle(); settle();
    n_checks++;
    if (ctl !== C_ZERO) begin $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO); n_fail++; end
    next_cycle(); settle();
    n_checks++;
    if (fsm_state !== 2'b00) begin $display("FAIL reset_state: got %b expected 00", fsm_state); n_fail++; end
    n_checks++;
    if (stall_count !== 16'd0) begin $display("FAIL reset_count: got %0h expected 0", stall_count); n_fail++; end
    n_checks++;
    if (mem_timeout !== 1'b0) begin $display("FAIL reset_timeout: got %b expected 0", mem_timeout); n_fail++; end
    reset = 1'b0;
    drive_idle();
    settle();
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL run_idle_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    // Load-use on rs1: exactly one bubble.
    next_cycle();
    drive_idle(); id_ex_memread = 1'b1; id_ex_writereg = 5'd5; if_id_rs1 = 5'd5;
    settle();
    n_checks++;
    if (ctl !== C_LU) begin $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, C_LU); n_fail++; end
    exp_stall = exp_stall + 1;
    // Writereg 0 never hazards.
    next_cycle();
    drive_idle(); id_ex_memread = 1'b1; id_ex_writereg = 5'd0; if_id_rs1 = 5'd0;
    settle();
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL lu_x0_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL lu_count1: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
    // Load-use on rs2 when rs2 is used.
    next_cycle();
    drive_idle(); id_ex_memread = 1'b1; id_ex_writereg = 5'd7; if_id_rs1 = 5'd3; if_id_rs2 = 5'd7; if_id_uses_rs2 = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_LU) begin $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, C_LU); n_fail++; end
    exp_stall = exp_stall + 1;
    // Same match, rs2 not read.
    next_cycle();
    if_id_uses_rs2 = 1'b0;
    settle();
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL lu_rs2_unused_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL lu_count2: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
    // Register match without a load.
    next_cycle();
    drive_idle(); id_ex_writereg = 5'd5; if_id_rs1 = 5'd5;
    settle();
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL lu_noload_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
  endtask

  task automatic test_mem_stall();
    next_cycle();
    drive_idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
    settle();
    n_checks++;
    if (ctl !== C_HOLD) begin $display("FAIL ms_c1_ctl: got %b expected %b", ctl, C_HOLD); n_fail++; end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      n_checks++;
      if (fsm_state !== 2'b01) begin $display("FAIL ms_wait_state: got %b expected 01", fsm_state); n_fail++; end
      n_checks++;
      if (ctl !== C_HOLD) begin $display("FAIL ms_wait_ctl: got %b expected %b", ctl, C_HOLD); n_fail++; end
    end
    next_cycle();
    dmem_ready = 1'b1;
    settle();
    n_checks++;
    if (fsm_state !== 2'b01) begin $display("FAIL ms_done_state: got %b expected 01", fsm_state); n_fail++; end
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL ms_done_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
    exp_stall = exp_stall + 3;
    next_cycle();
    drive_idle();
    settle();
    n_checks++;
    if (fsm_state !== 2'b00) begin $display("FAIL ms_back_state: got %b expected 00", fsm_state); n_fail++; end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL ms_count: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
  endtask

  task automatic test_branch_during_wait();
    next_cycle();
    drive_idle(); dmem_req = 1'b1;
    settle();
    next_cycle();
    ex_branch_taken = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_HOLD) begin $display("FAIL bw_pulse_ctl: got %b expected %b", ctl, C_HOLD); n_fail++; end
    next_cycle();
    ex_branch_taken = 1'b0;
    settle();
    next_cycle();
    dmem_ready = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_FLUSH) begin $display("FAIL bw_done_ctl: got %b expected %b", ctl, C_FLUSH); n_fail++; end
    exp_stall = exp_stall + 3;
    next_cycle();
    drive_idle();
    settle();
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL bw_pending_clear: got %b expected %b", ctl, C_RUN); n_fail++; end
    // A branch in the same cycle as a new stall wins over nothing, but is remembered.
    next_cycle();
    drive_idle(); dmem_req = 1'b1; ex_branch_taken = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_HOLD) begin $display("FAIL bs_prio_ctl: got %b expected %b", ctl, C_HOLD); n_fail++; end
    next_cycle();
    ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_FLUSH) begin $display("FAIL bs_done_ctl: got %b expected %b", ctl, C_FLUSH); n_fail++; end
    exp_stall = exp_stall + 1;
    next_cycle();
    drive_idle();
    settle();
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL bw_count: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
  endtask

  task automatic test_branch_and_load_use();
    next_cycle();
    drive_idle(); ex_branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_writereg = 5'd9; if_id_rs1 = 5'd9;
    settle();
    n_checks++;
    if (ctl !== C_FLUSH) begin $display("FAIL bl_ctl: got %b expected %b", ctl, C_FLUSH); n_fail++; end
    next_cycle();
    drive_idle(); dmem_ready = 1'b1;
    settle();
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL bl_count: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
    n_checks++;
    if (ctl !== C_RUN) begin $display("FAIL ready_noreq_ctl: got %b expected %b", ctl, C_RUN); n_fail++; end
    next_cycle(); settle();
    n_checks++;
    if (fsm_state !== 2'b00) begin $display("FAIL ready_noreq_state: got %b expected 00", fsm_state); n_fail++; end
    drive_idle();
  endtask

  task automatic test_timeout();
    next_cycle();
    drive_idle(); dmem_req = 1'b1;
    settle();
    // One RUN stall cycle plus four MEM_WAIT cycles.
    repeat (4) next_cycle();
    settle();
    n_checks++;
    if (fsm_state !== 2'b01) begin $display("FAIL to_last_wait_state: got %b expected 01", fsm_state); n_fail++; end
    n_checks++;
    if (mem_timeout !== 1'b0) begin $display("FAIL to_early_flag: got %b expected 0", mem_timeout); n_fail++; end
    exp_stall = exp_stall + 5;
    next_cycle(); settle();
    n_checks++;
    if (fsm_state !== 2'b10) begin $display("FAIL to_error_state: got %b expected 10", fsm_state); n_fail++; end
    n_checks++;
    if (mem_timeout !== 1'b1) begin $display("FAIL to_flag: got %b expected 1", mem_timeout); n_fail++; end
    n_checks++;
    if (ctl !== C_HOLD) begin $display("FAIL to_error_ctl: got %b expected %b", ctl, C_HOLD); n_fail++; end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL to_count: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
    // Completion in ERROR does not recover, and ERROR cycles are not counted.
    dmem_ready = 1'b1;
    repeat (2) next_cycle();
    settle();
    n_checks++;
    if ((fsm_state !== 2'b10) || (mem_timeout !== 1'b1)) begin
      $display("FAIL to_sticky: got state %b flag %b expected 10 1", fsm_state, mem_timeout); n_fail++;
    end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin $display("FAIL to_error_count: got %0d expected %0d", stall_count, exp_stall); n_fail++; end
    reset = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_ZERO) begin $display("FAIL to_reset_ctl: got %b expected %b", ctl, C_ZERO); n_fail++; end
    next_cycle();
    reset = 1'b0; drive_idle();
    settle();
    n_checks++;
    if ((fsm_state !== 2'b00) || (mem_timeout !== 1'b0) || (stall_count !== 16'd0)) begin
      $display("FAIL to_reset_clear: got state %b flag %b count %0d expected 00 0 0", fsm_state, mem_timeout, stall_count); n_fail++;
    end
    exp_stall = 0;
    // Reset during MEM_WAIT returns to RUN.
    next_cycle();
    dmem_req = 1'b1;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; drive_idle();
    settle();
    n_checks++;
    if ((fsm_state !== 2'b00) || (stall_count !== 16'd0)) begin
      $display("FAIL reset_midwait: got state %b count %0d expected 00 0", fsm_state, stall_count); n_fail++;
    end
  endtask

  task automatic test_saturation();
    next_cycle();
    drive_idle(); id_ex_memread = 1'b1; id_ex_writereg = 5'd4; if_id_rs1 = 5'd4;
    repeat (65534) next_cycle();
    settle();
    n_checks++;
    if (stall_count !== 16'hFFFE) begin $display("FAIL sat_preload: got %0h expected fffe", stall_count); n_fail++; end
    repeat (2) next_cycle();
    settle();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin $display("FAIL sat_reach: got %0h expected ffff", stall_count); n_fail++; end
    repeat (3) next_cycle();
    settle();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin $display("FAIL sat_hold: got %0h expected ffff", stall_count); n_fail++; end
    drive_idle();
  endtask

  // Test sequence and final report.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    reset     = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_mem_stall();
    test_branch_during_wait();
    test_branch_and_load_use();
    test_timeout();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: max MEM_WAIT cycles before error; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_id_rs1  in  5  rs1 of the instruction in decode.
REQ-005 if_id_rs2  in  5  rs2 of the instruction in decode.
REQ-006 if_id_uses_rs2  in  1  decode instruction reads rs2.
REQ-007 id_ex_memread  in  1  instruction in EX is a load.
REQ-008 id_ex_writereg  in  5  destination register of instruction in EX.
REQ-009 ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-010 dmem_req  in  1  MEM stage issues a data-memory access this cycle.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write  out  1  PC may advance.
REQ-013 if_id_write  out  1  IF/ID register may load.
REQ-014 if_id_flush  out  1  IF/ID register loads a NOP.
REQ-015 id_ex_bubble  out  1  ID/EX register loads all-zero controls.
REQ-016 ex_mem_hold  out  1  EX/MEM and MEM/WB registers hold.
REQ-017 mem_timeout  out  1  sticky memory-timeout error flag.
REQ-018 fsm_state  out  2  current state: RUN=00, MEM_WAIT=01, ERROR=10.
REQ-019 stall_count  out  16  saturating count of stalled cycles.

Function
REQ-020 Outputs pc_write..ex_mem_hold are combinational from registered state and current inputs; all other outputs are registered.
REQ-021 Load-use hazard = id_ex_memread & (id_ex_writereg != 0) & ((id_ex_writereg == if_id_rs1) | (if_id_uses_rs2 & id_ex_writereg == if_id_rs2)).
REQ-022 Memory stall = dmem_req & !dmem_ready.
REQ-023 RUN, no event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0.
REQ-024 RUN priority, highest first: memory stall, branch flush, load-use.
REQ-025 RUN + memory stall: pc_write=0, if_id_write=0, ex_mem_hold=1, flush=0, bubble=0; next state MEM_WAIT; wait_cnt <= 0; branch_pending <= ex_branch_taken.
REQ-026 RUN + taken branch, no memory stall: pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_write=1; remain RUN.
REQ-027 RUN + load-use only: pc_write=0, if_id_write=0, id_ex_bubble=1; remain RUN; exactly one bubble per load-use (hazard clears once bubble enters EX).
REQ-028 MEM_WAIT, dmem_ready=0: same outputs as REQ-025; branch_pending <= branch_pending | ex_branch_taken.
REQ-029 MEM_WAIT, dmem_ready=0, wait_cnt == TIMEOUT-1: next state ERROR, mem_timeout <= 1; else wait_cnt increments.
REQ-030 MEM_WAIT, dmem_ready=1: outputs per RUN rules (REQ-023..027) with branch = ex_branch_taken | branch_pending, memory stall ignored; next state RUN; branch_pending <= 0.
REQ-031 ERROR: pc_write=0, if_id_write=0, flush=0, bubble=0, ex_mem_hold=1; mem_timeout=1; exit only via reset.
REQ-032 stall_count increments by 1 each cycle pc_write=0 and state != ERROR; saturates at 16'hFFFF.
REQ-033 dmem_ready asserted while dmem_req=0 is ignored.
REQ-034 Encoding 2'b11 is unreachable; if entered, next state RUN.

Reset
REQ-035 reset=1 at rising edge: fsm_state=RUN, wait_cnt=0, branch_pending=0, stall_count=0, mem_timeout=0; dominates all other events including mid-MEM_WAIT and ERROR.
REQ-036 While reset=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0.

Verification
REQ-037 id_ex_memread=1, writereg=5, rs1=5, no mem stall -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1; writereg=0, rs1=0 -> no stall.
REQ-038 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> fsm_state 01 for 3 cycles, ex_mem_hold=1 for 3 cycles, back to RUN, stall_count=3.
REQ-039 Memory stall with ex_branch_taken pulsed 1 cycle during MEM_WAIT -> on dmem_ready cycle if_id_flush=1, id_ex_bubble=1, pc_write=1; pending cleared next cycle.
REQ-040 Simultaneous taken branch and load-use in RUN -> flush and bubble, pc_write=1, no stall, stall_count unchanged.
REQ-041 TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 MEM_WAIT cycles, mem_timeout=1 persists; reset=1 one cycle -> RUN, mem_timeout=0, stall_count=0.
REQ-042 stall_count preloaded to 16'hFFFE via 2 more stalled cycles -> reads 16'hFFFF, stays at 16'hFFFF.
